decode_stage: RTL and testbench

//  Registered ID stage: decodes one 32-bit instruction per cycle into control fields, holds them in an ID/EX register.

---
 rtl/decode_pkg.sv | 60 ++++++
 rtl/decode_if.sv | 46 ++++
 rtl/decode_fields.sv | 82 ++++++++
 rtl/decode_stage.sv | 129 ++++++++++++
 tb/tb_decode_stage.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: opcode/funct encodings, ALU opcodes and the decoded-bundle types
// shared by the ID stage and its combinational field decoder.
package decode_pkg;

  // Primary opcodes, instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JMP   = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LOAD  = 6'h20;
  localparam logic [5:0] OP_STORE = 6'h30;

  // R-type function codes, instruction[5:0]
  localparam logic [5:0] FN_NOP = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation presented to execute
  typedef enum logic [2:0] {
    ALU_NONE = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_AND  = 3'b011,
    ALU_OR   = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_BEQ  = 3'b110
  } alu_op_e;

  // Control fields that travel with the instruction into execute
  typedef struct packed {
    alu_op_e alu_op;
    logic    wb_enable;
    logic    mem_read;
    logic    mem_write;
    logic    i_type;
    logic    is_branch;
    logic    is_jump;
    logic    illegal;
  } decode_ctrl_t;

  // Full decoder result; register indices are kept at the 5-bit encoding
  // width and truncated by the stage to its architectural index width.
  typedef struct packed {
    decode_ctrl_t ctrl;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   write_reg;
    logic         uses_rs;
    logic         uses_rt;
  } decode_bundle_t;

  // Index width for a register file of nreg entries (at least one bit)
  function automatic int reg_aw(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/decode_if.sv
// decode_if: fetch-side and execute-side handshake of the ID stage.
// slave = the decode stage, master = the surrounding pipeline (fetch/execute).
interface decode_if #(
  parameter int PC_W   = 32,
  parameter int ADDR_W = 26,
  parameter int REG_AW = 5
) ();

  // Fetch side
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instruction;
  logic [PC_W-1:0]   in_pc;
  // Taken branch/jump squash from execute
  logic              flush;

  // Execute side
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [ADDR_W-1:0] addr_info;
  logic [2:0]        alu_op;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] write_reg;
  logic              wb_enable;
  logic              mem_read;
  logic              mem_write;
  logic              i_type;
  logic              is_branch;
  logic              is_jump;
  logic              illegal;

  modport slave (
    input  in_valid, instruction, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, addr_info, alu_op, rs, rt, write_reg,
           wb_enable, mem_read, mem_write, i_type, is_branch, is_jump, illegal
  );

  modport master (
    output in_valid, instruction, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, addr_info, alu_op, rs, rt, write_reg,
           wb_enable, mem_read, mem_write, i_type, is_branch, is_jump, illegal
  );

endinterface

// File: rtl/decode_fields.sv
// decode_fields: purely combinational instruction -> decoded bundle.
// Unknown opcodes/functs are flagged illegal and otherwise decode as a NOP.
module decode_fields
  import decode_pkg::*;
(
  input  logic [31:0]    i_instruction,
  output decode_bundle_t o_bundle
);

  logic [5:0] w_opcode;
  logic [5:0] w_funct;
  logic [4:0] w_rd;
  logic       w_unused_shamt;

  assign w_opcode       = i_instruction[31:26];
  assign w_funct        = i_instruction[5:0];
  assign w_rd           = i_instruction[15:11];
  assign w_unused_shamt = ^i_instruction[10:6];

  // Opcode/funct decode into control fields and register-usage flags
  always_comb begin
    o_bundle             = '0;
    o_bundle.ctrl.alu_op = ALU_NONE;
    o_bundle.rs          = i_instruction[25:21];
    o_bundle.rt          = i_instruction[20:16];
    case (w_opcode)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADD:  o_bundle.ctrl.alu_op = ALU_ADD;
          FN_SUB:  o_bundle.ctrl.alu_op = ALU_SUB;
          FN_AND:  o_bundle.ctrl.alu_op = ALU_AND;
          FN_OR:   o_bundle.ctrl.alu_op = ALU_OR;
          FN_SLT:  o_bundle.ctrl.alu_op = ALU_SLT;
          FN_NOP:  o_bundle.ctrl.alu_op = ALU_NONE;
          default: o_bundle.ctrl.illegal = 1'b1;
        endcase
        // Every legal R-type except NOP reads rs/rt and writes rd
        if (w_funct != FN_NOP && !o_bundle.ctrl.illegal) begin
          o_bundle.ctrl.wb_enable = 1'b1;
          o_bundle.uses_rs        = 1'b1;
          o_bundle.uses_rt        = 1'b1;
          o_bundle.write_reg      = w_rd;
        end
      end
      OP_ADDI: begin
        o_bundle.ctrl.alu_op    = ALU_ADD;
        o_bundle.ctrl.wb_enable = 1'b1;
        o_bundle.ctrl.i_type    = 1'b1;
        o_bundle.uses_rs        = 1'b1;
        o_bundle.write_reg      = i_instruction[20:16];
      end
      OP_LOAD: begin
        o_bundle.ctrl.alu_op    = ALU_ADD;
        o_bundle.ctrl.wb_enable = 1'b1;
        o_bundle.ctrl.mem_read  = 1'b1;
        o_bundle.ctrl.i_type    = 1'b1;
        o_bundle.uses_rs        = 1'b1;
        o_bundle.write_reg      = i_instruction[20:16];
      end
      OP_STORE: begin
        o_bundle.ctrl.alu_op    = ALU_ADD;
        o_bundle.ctrl.mem_write = 1'b1;
        o_bundle.ctrl.i_type    = 1'b1;
        o_bundle.uses_rs        = 1'b1;
        o_bundle.uses_rt        = 1'b1;
      end
      OP_BEQ: begin
        o_bundle.ctrl.alu_op    = ALU_BEQ;
        o_bundle.ctrl.is_branch = 1'b1;
        o_bundle.uses_rs        = 1'b1;
        o_bundle.uses_rt        = 1'b1;
      end
      OP_JMP: begin
        o_bundle.ctrl.is_jump = 1'b1;
      end
      default: begin
        o_bundle.ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered ID stage with valid/ready on both sides, a one-cycle
// load-use interlock and a synchronous flush.
// Optional feature macro: DECODE_PERF_EN adds o_stall_cnt / o_illegal_cnt.
module decode_stage
  import decode_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int ADDR_W = 26,
  parameter int PC_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  decode_if.slave     io_bus
`ifdef DECODE_PERF_EN
  ,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_illegal_cnt
`endif
);

  localparam int REG_AW = reg_aw(NREG);

  decode_bundle_t    w_bundle;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_write_reg;
  logic              w_hazard;
  logic              w_in_ready;
  logic              w_accept;

  logic              r_out_valid;
  logic [PC_W-1:0]   r_out_pc;
  logic [ADDR_W-1:0] r_addr_info;
  decode_ctrl_t      r_ctrl;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_write_reg;

  decode_fields u_fields (
    .i_instruction (io_bus.instruction),
    .o_bundle      (w_bundle)
  );

  assign w_rs        = w_bundle.rs[REG_AW-1:0];
  assign w_rt        = w_bundle.rt[REG_AW-1:0];
  assign w_write_reg = w_bundle.write_reg[REG_AW-1:0];

  // Load-use interlock: the held LOAD's destination is read by the presented
  // instruction. Register 0 is hard-wired and never interlocks.
  assign w_hazard = r_out_valid && r_ctrl.mem_read && (r_write_reg != '0) &&
                    ((w_bundle.uses_rs && (r_write_reg == w_rs)) ||
                     (w_bundle.uses_rt && (r_write_reg == w_rt)));

  // Reset and flush are folded into ready so an accept can never race them
  assign w_in_ready = !reset && !io_bus.flush && !w_hazard &&
                      (!r_out_valid || io_bus.out_ready);
  assign w_accept   = io_bus.in_valid && w_in_ready;

  // ID/EX register: reset/flush drop, accept loads, consume bubbles, else hold
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_addr_info <= '0;
      r_ctrl      <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_write_reg <= '0;
    end else if (io_bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_pc    <= io_bus.in_pc;
      r_addr_info <= io_bus.instruction[ADDR_W-1:0];
      r_ctrl      <= w_bundle.ctrl;
      r_rs        <= w_rs;
      r_rt        <= w_rt;
      r_write_reg <= w_write_reg;
    end else if (io_bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_pc    = r_out_pc;
  assign io_bus.addr_info = r_addr_info;
  assign io_bus.alu_op    = r_ctrl.alu_op;
  assign io_bus.rs        = r_rs;
  assign io_bus.rt        = r_rt;
  assign io_bus.write_reg = r_write_reg;
  assign io_bus.wb_enable = r_ctrl.wb_enable;
  assign io_bus.mem_read  = r_ctrl.mem_read;
  assign io_bus.mem_write = r_ctrl.mem_write;
  assign io_bus.i_type    = r_ctrl.i_type;
  assign io_bus.is_branch = r_ctrl.is_branch;
  assign io_bus.is_jump   = r_ctrl.is_jump;
  assign io_bus.illegal   = r_ctrl.illegal;

`ifdef DECODE_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_illegal_cnt;
  logic        w_hazard_bubble;

  // A bubble is issued on the edge where a waiting reader is blocked by the
  // interlock while execute drains the LOAD; a downstream stall does not count twice.
  assign w_hazard_bubble = w_hazard && io_bus.in_valid && io_bus.out_ready &&
                           !io_bus.flush;

  // Performance counters: survive flush, cleared only by reset, wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt   <= '0;
      r_illegal_cnt <= '0;
    end else begin
      if (w_hazard_bubble) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_accept && w_bundle.ctrl.illegal) begin
        r_illegal_cnt <= r_illegal_cnt + 32'd1;
      end
    end
  end

  assign o_stall_cnt   = r_stall_cnt;
  assign o_illegal_cnt = r_illegal_cnt;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed-vector bench for decode_stage with hand-computed
// expectations. Build with DECODE_PERF_EN defined to also check the counters.
module tb_decode_stage;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

`ifdef DECODE_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] illegal_cnt;
`endif

  decode_if #(.PC_W(32), .ADDR_W(26), .REG_AW(5)) bus ();

  decode_stage #(.NREG(32), .ADDR_W(26), .PC_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
`ifdef DECODE_PERF_EN
    ,
    .o_stall_cnt   (stall_cnt),
    .o_illegal_cnt (illegal_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction encodings
  localparam logic [31:0] I_ADD_3_1_2 = 32'h0022_1820; // ADD r3,r1,r2
  localparam logic [31:0] I_LOAD_R5   = 32'h8005_0000; // LOAD r5,0(r0)
  localparam logic [31:0] I_ADD_7_5_6 = 32'h00A6_3820; // ADD r7,r5,r6
  localparam logic [31:0] I_STORE_R5  = 32'hC005_0000; // STORE r5,0(r0)
  localparam logic [31:0] I_LOAD_R0   = 32'h8000_0000; // LOAD r0
  localparam logic [31:0] I_ADD_4_0_0 = 32'h0000_2020; // ADD r4,r0,r0
  localparam logic [31:0] I_BEQ       = 32'h1022_0003; // BEQ r1,r2,+3
  localparam logic [31:0] I_ADDI_9    = 32'h2029_0007; // ADDI r9,r1,7
  localparam logic [31:0] I_JMP       = 32'h0800_0010; // JMP 0x10
  localparam logic [31:0] I_ILL_OP    = 32'hFC00_0000; // opcode 0x3F
  localparam logic [31:0] I_ILL_FN    = 32'h0022_183F; // R-type funct 0x3F

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid    = 1'b1;
    bus.instruction = instr;
    bus.in_pc       = pc;
    $display("[%0t] present instr=0x%08h pc=0x%08h", $time, instr, pc);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.instruction = '0;
    bus.in_pc       = '0;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b1;

    // Reset held for two cycles
    tick(); tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_alu_op",    32'(bus.alu_op),    32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_write_reg", 32'(bus.write_reg), 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // ADD r3,r1,r2: one-cycle latency
    issue(I_ADD_3_1_2, 32'h100);
    tick(); idle();
    chk("add_out_valid", 32'(bus.out_valid), 32'd1);
    chk("add_alu_op",    32'(bus.alu_op),    32'd1);
    chk("add_write_reg", 32'(bus.write_reg), 32'd3);
    chk("add_wb_enable", 32'(bus.wb_enable), 32'd1);
    chk("add_rs",        32'(bus.rs),        32'd1);
    chk("add_rt",        32'(bus.rt),        32'd2);
    chk("add_out_pc",    bus.out_pc,         32'h100);

    // LOAD r5 then ADD reading r5 via rs: one bubble
    issue(I_LOAD_R5, 32'h104);
    #1 chk("ld_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("ld_mem_read",  32'(bus.mem_read),  32'd1);
    chk("ld_write_reg", 32'(bus.write_reg), 32'd5);
    chk("ld_i_type",    32'(bus.i_type),    32'd1);
    issue(I_ADD_7_5_6, 32'h108);
    #1 chk("hz_rs_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("hz_rs_bubble",    32'(bus.out_valid), 32'd0);
    chk("hz_rs_in_ready2", 32'(bus.in_ready),  32'd1);
    tick(); idle();
    chk("hz_rs_out_valid", 32'(bus.out_valid), 32'd1);
    chk("hz_rs_write_reg", 32'(bus.write_reg), 32'd7);
    chk("hz_rs_rs",        32'(bus.rs),        32'd5);
    chk("hz_rs_rt",        32'(bus.rt),        32'd6);
    chk("hz_rs_out_pc",    bus.out_pc,         32'h108);

    // LOAD r5 then STORE reading r5 via rt: one bubble
    issue(I_LOAD_R5, 32'h10C);
    tick();
    issue(I_STORE_R5, 32'h110);
    #1 chk("hz_rt_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("hz_rt_bubble", 32'(bus.out_valid), 32'd0);
    tick(); idle();
    chk("st_out_valid", 32'(bus.out_valid), 32'd1);
    chk("st_mem_write", 32'(bus.mem_write), 32'd1);
    chk("st_write_reg", 32'(bus.write_reg), 32'd0);
    chk("st_alu_op",    32'(bus.alu_op),    32'd1);
    chk("st_wb_enable", 32'(bus.wb_enable), 32'd0);

    // LOAD r0 then reader of r0: no interlock
    issue(I_LOAD_R0, 32'h114);
    tick();
    issue(I_ADD_4_0_0, 32'h118);
    #1 chk("r0_in_ready", 32'(bus.in_ready), 32'd1);
    tick(); idle();
    chk("r0_out_valid", 32'(bus.out_valid), 32'd1);
    chk("r0_write_reg", 32'(bus.write_reg), 32'd4);
    chk("r0_out_pc",    bus.out_pc,         32'h118);
    tick();
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);

    // BEQ held for three cycles with execute stalled
    bus.out_ready = 1'b0;
    issue(I_BEQ, 32'h200);
    tick();
    issue(I_ADDI_9, 32'h204);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("beq_out_valid", 32'(bus.out_valid), 32'd1);
      chk("beq_alu_op",    32'(bus.alu_op),    32'd6);
      chk("beq_is_branch", 32'(bus.is_branch), 32'd1);
      chk("beq_in_ready",  32'(bus.in_ready),  32'd0);
      chk("beq_out_pc",    bus.out_pc,         32'h200);
      chk("beq_addr_info", 32'(bus.addr_info), 32'h022_0003);
      tick();
    end
    bus.out_ready = 1'b1;
    #1 chk("beq_release_in_ready", 32'(bus.in_ready), 32'd1);
    tick(); idle();
    chk("addi_out_valid", 32'(bus.out_valid), 32'd1);
    chk("addi_alu_op",    32'(bus.alu_op),    32'd1);
    chk("addi_write_reg", 32'(bus.write_reg), 32'd9);
    chk("addi_i_type",    32'(bus.i_type),    32'd1);
    chk("addi_out_pc",    bus.out_pc,         32'h204);
    tick();

    // Flush drops the held JMP and the presented ADD together
    bus.out_ready = 1'b0;
    issue(I_JMP, 32'h300);
    tick();
    chk("jmp_out_valid", 32'(bus.out_valid), 32'd1);
    chk("jmp_is_jump",   32'(bus.is_jump),   32'd1);
    chk("jmp_alu_op",    32'(bus.alu_op),    32'd0);
    chk("jmp_addr_info", 32'(bus.addr_info), 32'h10);
    bus.flush = 1'b1;
    issue(I_ADD_3_1_2, 32'h304);
    #1 chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    idle();
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_hold_jump", 32'(bus.is_jump),   32'd1);
    chk("flush_hold_pc",   bus.out_pc,         32'h300);

    // Illegal opcode then illegal funct, back to back
    issue(I_ILL_OP, 32'h400);
    tick();
    issue(I_ILL_FN, 32'h404);
    chk("ill_op_out_valid", 32'(bus.out_valid), 32'd1);
    chk("ill_op_illegal",   32'(bus.illegal),   32'd1);
    chk("ill_op_alu_op",    32'(bus.alu_op),    32'd0);
    chk("ill_op_wb_enable", 32'(bus.wb_enable), 32'd0);
    tick(); idle();
    chk("ill_fn_illegal",   32'(bus.illegal),   32'd1);
    chk("ill_fn_alu_op",    32'(bus.alu_op),    32'd0);
    chk("ill_fn_wb_enable", 32'(bus.wb_enable), 32'd0);
    chk("ill_fn_write_reg", 32'(bus.write_reg), 32'd0);
    chk("ill_fn_out_pc",    bus.out_pc,         32'h404);
`ifdef DECODE_PERF_EN
    chk("perf_stall_cnt",   stall_cnt,   32'd2);
    chk("perf_illegal_cnt", illegal_cnt, 32'd2);
`endif

    // Reset mid-stream clears the output register
    tick();
    issue(I_ADD_3_1_2, 32'h500);
    reset = 1'b1;
    #1 chk("rst2_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    reset = 1'b0;
    idle();
    chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst2_illegal",   32'(bus.illegal),   32'd0);
    chk("rst2_out_pc",    bus.out_pc,         32'd0);
`ifdef DECODE_PERF_EN
    chk("rst2_stall_cnt",   stall_cnt,   32'd0);
    chk("rst2_illegal_cnt", illegal_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
